// File: rtl/oscillator.sv
// Tone generator timebase: divides clk down to a sample tick at STEPS x the
// requested note frequency, and advances a phase counter on each tick whose
// MSB is the square-wave tone output.
module oscillator #(
  parameter int unsigned CLK_HZ = 10_000_000,
  parameter int unsigned STEPS  = 256
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [8:0] freq,
  input  logic       playSound,
  output logic       at_max,
  output logic       state
);

  localparam int unsigned PW = $clog2(STEPS);

  // Tone output levels
  localparam logic OFF = 1'b0;
  localparam logic ON  = 1'b1;

  logic [31:0]   divisor;
  logic [15:0]   max_count;
  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          at_max_q, at_max_d;
  logic          run;
  logic          wrap;

  // Terminal count for the divider; freq == 0 is silent, so the divide is guarded.
  always_comb begin
    divisor   = 32'(STEPS) * 32'(freq);
    max_count = '0;
    if (freq != '0) begin
      max_count = 16'(CLK_HZ / divisor);
    end
  end

  // Next-state logic: idle clears everything, otherwise count and wrap.
  // The >= compare makes a frequency change that lands below the current
  // count wrap on the next edge instead of running the counter around.
  always_comb begin
    run      = playSound && (freq != '0);
    wrap     = (cnt_q >= max_count);
    cnt_d    = '0;
    phase_d  = '0;
    at_max_d = 1'b0;
    if (run) begin
      if (wrap) begin
        cnt_d    = '0;
        at_max_d = 1'b1;
        phase_d  = phase_q + 1'b1;
      end else begin
        cnt_d    = cnt_q + 16'd1;
        at_max_d = 1'b0;
        phase_d  = phase_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      at_max_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      at_max_q <= at_max_d;
    end
  end

  assign at_max = at_max_q;
  assign state  = phase_q[PW-1] ? ON : OFF;

endmodule

// File: tb/tb_oscillator.sv
// Self-checking bench for oscillator: table of first-pulse periods, directed
// corner sequences, and a randomized run against a tick/phase reference model.
module tb_oscillator;

  logic       clk;
  logic       nRst;
  logic [8:0] freq;
  logic       playSound;
  logic       at_max;
  logic       state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  oscillator #(.CLK_HZ(10_000_000), .STEPS(256)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .freq      (freq),
    .playSound (playSound),
    .at_max    (at_max),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  f;
    int unsigned period;  // cycles between sample ticks = floor(1e7/(256*f)) + 1
  } vec_t;

  vec_t vecs [6];

  // Reference model state: edges since last restart/tick, ticks since restart.
  int unsigned m_el;
  int unsigned m_ticks;
  logic        m_pulse;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b0;
    #2;
    nRst = 1'b1;
  endtask

  task automatic model_reset();
    m_el    = 0;
    m_ticks = 0;
    m_pulse = 1'b0;
  endtask

  // One clock edge of the reference model using the inputs the DUT samples.
  task automatic model_edge();
    int unsigned mc;
    if (!playSound || freq == 0) begin
      model_reset();
    end else begin
      mc = 10_000_000 / (256 * int'(freq));
      if (m_el >= mc) begin
        m_el    = 0;
        m_pulse = 1'b1;
        m_ticks = m_ticks + 1;
      end else begin
        m_el    = m_el + 1;
        m_pulse = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{f: 9'd440, period: 89};
    vecs[1] = '{f: 9'd311, period: 126};
    vecs[2] = '{f: 9'd262, period: 150};
    vecs[3] = '{f: 9'd511, period: 77};
    vecs[4] = '{f: 9'd500, period: 79};
    vecs[5] = '{f: 9'd300, period: 131};

    nRst      = 1'b1;
    freq      = 9'd0;
    playSound = 1'b0;

    // Asynchronous reset with no clock edge, then release mid-cycle.
    #2;
    nRst = 1'b0;
    #1;
    check("async_rst_at_max", at_max, 1'b0);
    check("async_rst_state", state, 1'b0);
    tick();
    @(negedge clk);
    nRst = 1'b1;
    tick();
    check("post_rst_at_max", at_max, 1'b0);

    // Table: pulse only at multiples of the period, state stays low meanwhile.
    foreach (vecs[i]) begin
      playSound = 1'b0;
      do_reset();
      freq      = vecs[i].f;
      playSound = 1'b1;
      for (int unsigned e = 1; e <= 2 * vecs[i].period + 1; e++) begin
        tick();
        check($sformatf("tbl_f%0d_e%0d", vecs[i].f, e), at_max,
              (e == vecs[i].period) || (e == 2 * vecs[i].period));
      end
      check($sformatf("tbl_f%0d_state", vecs[i].f), state, 1'b0);
    end

    // Silence: playSound low with a valid frequency.
    playSound = 1'b0;
    do_reset();
    freq = 9'd262;
    for (int unsigned e = 1; e <= 160; e++) begin
      tick();
      check("silent_at_max", at_max, 1'b0);
      check("silent_state", state, 1'b0);
    end

    // freq == 0 with playSound high is also silent.
    freq      = 9'd0;
    playSound = 1'b1;
    for (int unsigned e = 1; e <= 100; e++) begin
      tick();
      check("f0_at_max", at_max, 1'b0);
    end

    // Frequency drops below the current count: wrap on the next edge.
    playSound = 1'b0;
    do_reset();
    freq      = 9'd262;
    playSound = 1'b1;
    for (int unsigned e = 1; e <= 120; e++) begin
      tick();
      check("chg_pre_at_max", at_max, 1'b0);
    end
    freq = 9'd440;
    tick();
    check("chg_wrap_at_max", at_max, 1'b1);
    for (int unsigned e = 1; e <= 89; e++) begin
      tick();
      check("chg_spacing_at_max", at_max, e == 89);
    end

    // State toggles after 128 ticks of 150 cycles.
    playSound = 1'b0;
    do_reset();
    freq      = 9'd262;
    playSound = 1'b1;
    for (int unsigned e = 1; e <= 19199; e++) tick();
    check("state_before_128", state, 1'b0);
    tick();
    check("state_at_128", state, 1'b1);
    check("state_tick_128", at_max, 1'b1);

    // Asynchronous reset mid-operation while state is high.
    @(negedge clk);
    nRst = 1'b0;
    #1;
    check("mid_rst_state", state, 1'b0);
    check("mid_rst_at_max", at_max, 1'b0);
    #1;
    nRst = 1'b1;
    for (int unsigned e = 1; e <= 150; e++) begin
      tick();
      check("restart_at_max", at_max, e == 150);
    end

    // Randomized run against the reference model.
    playSound = 1'b0;
    do_reset();
    model_reset();
    begin
      logic [8:0] fset [6];
      int unsigned seg;
      fset[0] = 9'd511; fset[1] = 9'd480; fset[2] = 9'd450;
      fset[3] = 9'd440; fset[4] = 9'd400; fset[5] = 9'd0;
      seg = 0;
      for (int unsigned c = 0; c < 40000; c++) begin
        if (seg == 0) begin
          seg       = $urandom_range(2000, 100);
          freq      = ($urandom_range(9, 0) == 0) ? fset[5] : fset[$urandom_range(4, 0)];
          playSound = ($urandom_range(19, 0) != 0);
        end
        seg--;
        model_edge();
        tick();
        check("rnd_at_max", at_max, m_pulse);
        check("rnd_state", state, (m_ticks % 256) >= 128);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
